pe_seq_ctrl: RTL and testbench
==============================

Name: pe_seq_ctrl

Overview:
Sequencer for one pe_core MAC lane. On a start command it walks the activation and weight buffers to compute NUM_OUT dot products of LEN terms each. It drives the buffer read ports and the PE controls (pe_en, reg_reset, mode_sel), then captures each finished accumulator value and hands it downstream over a valid/ready interface. It sits between the layer scheduler and the PE/buffer pair.

Parameters:
ADDR_W, 10, activation/weight buffer address width
LEN_W, 10, width of the term count per output
OUT_W, 8, width of the output-channel count
ACC_W, 20, width of the PE result bus
RD_LAT, 1, buffer read latency in cycles (>=1)
PE_LAT, 2, cycles from the last pe_en to a valid pe_result

Ports:
clk  in  1  work clock
reset  in  1  synchronous reset, active-high
cfg_start  in  1  one-cycle start pulse; config sampled on the same cycle
cfg_len  in  LEN_W  terms per output (K)
cfg_num_out  in  OUT_W  number of outputs (N)
cfg_relu  in  1  0: raw, 1: ReLU; drives mode_sel for the whole job
cfg_act_base  in  ADDR_W  activation base address
cfg_wgt_base  in  ADDR_W  weight base address
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse at job end
buf_rd_en  out  1  read strobe to both buffers
act_addr  out  ADDR_W  activation read address
wgt_addr  out  ADDR_W  weight read address
pe_en  out  1  MAC enable, aligned to buffer data
pe_reg_reset  out  1  accumulator clear, aligned to the first term
pe_mode_sel  out  1  registered copy of cfg_relu
pe_result  in  ACC_W  PE accumulator output
res_valid  out  1  result available
res_ready  in  1  downstream accept
res_data  out  ACC_W  captured result
res_idx  out  OUT_W  output index of res_data

Behaviour:
- Reset: FSM goes to IDLE. busy, done, buf_rd_en, pe_en, pe_reg_reset, pe_mode_sel and res_valid are 0. All addresses, res_data, res_idx and the counters are 0. Reset applies mid-job too: the job is aborted and the RD_LAT delay pipe is flushed.
- FSM states: IDLE, ISSUE, DRAIN, OUTPUT, FIN.
- IDLE: on cfg_start, latch all cfg_* values and go to ISSUE. Set j=0, k=0, act_addr=act_base, wgt_addr=wgt_base.
- Zero-length jobs: if cfg_len==0 or cfg_num_out==0, go to FIN instead. No reads and no results are produced.
- cfg_start while not in IDLE is ignored.
- ISSUE: one term per cycle. buf_rd_en=1 and both addresses are valid on the same cycle. act_addr=act_base+k; wgt_addr=wgt_base+j*K+k, generated incrementally with no multiplier. k increments each cycle.
- ISSUE exit: after the term with k==K-1, go to DRAIN.
- Address wrap: addresses wrap modulo 2^ADDR_W; no error is flagged.
- PE alignment: buf_rd_en and a first-term flag (k==0) pass through an RD_LAT-deep delay pipe. pe_en equals buf_rd_en delayed RD_LAT cycles. pe_reg_reset equals the first-term flag delayed RD_LAT cycles and coincides with the first pe_en of each output. The PE loads the product instead of accumulating on that cycle.
- DRAIN: counter runs for RD_LAT+PE_LAT cycles, counted from the cycle after the last ISSUE cycle. On the final DRAIN cycle, capture pe_result into res_data, set res_idx=j and res_valid=1, then go to OUTPUT.
- OUTPUT: hold res_valid, res_data and res_idx stable until res_valid&&res_ready.
- OUTPUT on handshake: clear res_valid on the next edge. If j==N-1 go to FIN; otherwise j++, k=0, act_addr=act_base, go to ISSUE. wgt_addr continues from where it stopped.
- Backpressure: res_ready low stalls the controller; there is no issue overlap across outputs.
- FIN: done=1 for exactly one cycle, then IDLE. busy goes to 0 on the same edge that done goes to 1.
- pe_mode_sel is held at the latched cfg_relu from the start accept until the next start. ReLU is applied inside the PE; res_data is passed through unmodified.

Test Plan:
- K=4, N=2, act_base=0x10, wgt_base=0x100, RD_LAT=1 -> act_addr reads 0x10..0x13 twice. wgt_addr reads 0x100..0x107. pe_reg_reset pulses exactly 2 times, each aligned with the first of 4 pe_en. done pulses once.
- K=3, N=1, PE model accumulating a*b, a={1,2,3}, b={-1,4,-2} -> res_data=1, res_idx=0. With cfg_relu=1, pe_mode_sel=1 throughout the job.
- N=3 with res_ready held low 5 cycles on output 1 -> res_valid/res_data stable for those 5 cycles. No buf_rd_en until the handshake. res_idx sequence is 0,1,2.
- cfg_len=0, cfg_num_out=5 -> no buf_rd_en and no res_valid; done pulses 2 cycles after start. A second cfg_start mid-job is ignored and the address trace is unchanged.
- reset asserted during ISSUE at k=2 -> next cycle all outputs are 0 and state is IDLE. A new start runs a clean job from k=0.
- act_base=0x3FE, K=4 -> act_addr sequence 0x3FE, 0x3FF, 0x000, 0x001.

Source files
------------

// File: rtl/pe_seq_ctrl_if.sv
// Bundle between the MAC-lane sequencer and its scheduler, buffers, PE and result sink.
// master = the sequencer, slave = everything around it.
interface pe_seq_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 10,
    parameter int OUT_W  = 8,
    parameter int ACC_W  = 20
);
    logic              cfg_start;
    logic [LEN_W-1:0]  cfg_len;
    logic [OUT_W-1:0]  cfg_num_out;
    logic              cfg_relu;
    logic [ADDR_W-1:0] cfg_act_base;
    logic [ADDR_W-1:0] cfg_wgt_base;
    logic              busy;
    logic              done;
    logic              buf_rd_en;
    logic [ADDR_W-1:0] act_addr;
    logic [ADDR_W-1:0] wgt_addr;
    logic              pe_en;
    logic              pe_reg_reset;
    logic              pe_mode_sel;
    logic [ACC_W-1:0]  pe_result;
    logic              res_valid;
    logic              res_ready;
    logic [ACC_W-1:0]  res_data;
    logic [OUT_W-1:0]  res_idx;

    modport master (
        input  cfg_start, cfg_len, cfg_num_out, cfg_relu, cfg_act_base, cfg_wgt_base,
        input  pe_result, res_ready,
        output busy, done, buf_rd_en, act_addr, wgt_addr,
        output pe_en, pe_reg_reset, pe_mode_sel,
        output res_valid, res_data, res_idx
    );

    modport slave (
        output cfg_start, cfg_len, cfg_num_out, cfg_relu, cfg_act_base, cfg_wgt_base,
        output pe_result, res_ready,
        input  busy, done, buf_rd_en, act_addr, wgt_addr,
        input  pe_en, pe_reg_reset, pe_mode_sel,
        input  res_valid, res_data, res_idx
    );
endinterface

// File: rtl/pe_seq_ctrl.sv
// Sequencer for one pe_core MAC lane: walks act/wgt buffers for NUM_OUT dot products
// of LEN terms, aligns PE controls to buffer data and hands each result downstream.
module pe_seq_ctrl #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 10,
    parameter int OUT_W  = 8,
    parameter int ACC_W  = 20,
    parameter int RD_LAT = 1,
    parameter int PE_LAT = 2
) (
    input  logic          clk,
    input  logic          reset,
    pe_seq_ctrl_if.master bus
);
    localparam int DRN = RD_LAT + PE_LAT;
    localparam int DW  = $clog2(DRN + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, OUTPUT, FIN} state_t;

    state_t            state, state_nxt;
    logic [LEN_W-1:0]  len_q, k;
    logic [OUT_W-1:0]  nout_q, j;
    logic [ADDR_W-1:0] act_base_q, act_addr_q, wgt_addr_q;
    logic [DW-1:0]     dcnt;
    logic [ACC_W-1:0]  res_data_q;
    logic [OUT_W-1:0]  res_idx_q;
    logic              busy_q, done_q, mode_q, res_valid_q;
    logic              rd_en, start_acc, drain_last, res_hs, zero_job;
    logic [RD_LAT:0]   vld_pipe, first_pipe;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        rd_en      = 1'b0;
        start_acc  = 1'b0;
        drain_last = 1'b0;
        res_hs     = 1'b0;
        zero_job   = (bus.cfg_len == '0) || (bus.cfg_num_out == '0);
        unique case (state)
            IDLE: if (bus.cfg_start) begin
                start_acc = 1'b1;
                state_nxt = zero_job ? FIN : ISSUE;
            end
            ISSUE: begin
                rd_en = 1'b1;
                if (k == len_q - 1'b1) state_nxt = DRAIN;
            end
            DRAIN: if (dcnt == DW'(DRN - 1)) begin
                drain_last = 1'b1;
                state_nxt  = OUTPUT;
            end
            OUTPUT: if (res_valid_q && bus.res_ready) begin
                res_hs    = 1'b1;
                state_nxt = (j == nout_q - 1'b1) ? FIN : ISSUE;
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_q       <= '0;
            nout_q      <= '0;
            act_base_q  <= '0;
            act_addr_q  <= '0;
            wgt_addr_q  <= '0;
            k           <= '0;
            j           <= '0;
            dcnt        <= '0;
            res_data_q  <= '0;
            res_idx_q   <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mode_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dcnt   <= (state == DRAIN) ? dcnt + 1'b1 : '0;
            if (start_acc) begin
                len_q      <= bus.cfg_len;
                nout_q     <= bus.cfg_num_out;
                act_base_q <= bus.cfg_act_base;
                act_addr_q <= bus.cfg_act_base;
                wgt_addr_q <= bus.cfg_wgt_base;
                mode_q     <= bus.cfg_relu;
                busy_q     <= 1'b1;
                j          <= '0;
                k          <= '0;
            end
            // wgt_addr is never rewound: j*K+k falls out of running it straight through
            if (rd_en) begin
                k          <= k + 1'b1;
                act_addr_q <= act_addr_q + 1'b1;
                wgt_addr_q <= wgt_addr_q + 1'b1;
            end
            if (drain_last) begin
                res_data_q  <= bus.pe_result;
                res_idx_q   <= j;
                res_valid_q <= 1'b1;
            end
            if (res_hs) begin
                res_valid_q <= 1'b0;
                if (state_nxt == ISSUE) begin
                    j          <= j + 1'b1;
                    k          <= '0;
                    act_addr_q <= act_base_q;
                end
            end
            if (state == FIN) begin
                done_q <= 1'b1;
                busy_q <= 1'b0;
            end
        end
    end

    // Read strobe and first-term flag ride RD_LAT stages so they meet the buffer data
    assign vld_pipe[0]   = rd_en;
    assign first_pipe[0] = rd_en && (k == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe[RD_LAT:1]   <= '0;
            first_pipe[RD_LAT:1] <= '0;
        end else begin
            vld_pipe[RD_LAT:1]   <= vld_pipe[RD_LAT-1:0];
            first_pipe[RD_LAT:1] <= first_pipe[RD_LAT-1:0];
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.buf_rd_en    = rd_en;
    assign bus.act_addr     = act_addr_q;
    assign bus.wgt_addr     = wgt_addr_q;
    assign bus.pe_en        = vld_pipe[RD_LAT];
    assign bus.pe_reg_reset = first_pipe[RD_LAT];
    assign bus.pe_mode_sel  = mode_q;
    assign bus.res_valid    = res_valid_q;
    assign bus.res_data     = res_data_q;
    assign bus.res_idx      = res_idx_q;
endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Randomized scoreboard bench for pe_seq_ctrl with behavioural buffer/PE models.
module tb_pe_seq_ctrl;
    localparam int ADDR_W = 10, LEN_W = 10, OUT_W = 8, ACC_W = 20, RD_LAT = 1, PE_LAT = 2;

    typedef struct { logic [ADDR_W-1:0] a; logic [ADDR_W-1:0] w; } addr_t;
    typedef struct { logic [ACC_W-1:0] d; logic [OUT_W-1:0] i; } res_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pe_seq_ctrl_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .OUT_W(OUT_W), .ACC_W(ACC_W)) bus ();

    pe_seq_ctrl #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .OUT_W(OUT_W), .ACC_W(ACC_W),
                  .RD_LAT(RD_LAT), .PE_LAT(PE_LAT)) u_dut (.clk(clk), .reset(reset), .bus(bus));

    int n_cmp = 0, n_fail = 0;
    addr_t addr_q[$];
    res_t  res_q[$];
    logic signed [7:0] act_mem [1024];
    logic signed [7:0] wgt_mem [1024];
    int cur_k = 0, en_base = 0, rr_base = 0, done_base = 0;
    int n_en = 0, n_rr = 0, n_done = 0;
    bit exp_relu = 0;
    int rdy_mode = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Buffers with one cycle of read latency, PE with two cycles from pe_en to result
    logic signed [7:0]  act_d, wgt_d;
    logic signed [19:0] acc, prod, pe_q;
    assign prod = act_d * wgt_d;
    always @(posedge clk) begin
        if (bus.buf_rd_en) begin
            act_d <= act_mem[bus.act_addr];
            wgt_d <= wgt_mem[bus.wgt_addr];
        end
        if (bus.pe_en) acc <= (bus.pe_reg_reset ? 20'sd0 : acc) + prod;
        pe_q <= (bus.pe_mode_sel && acc < 0) ? 20'sd0 : acc;
    end
    assign bus.pe_result = pe_q;

    initial begin
        int stall = 0;
        bus.res_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (!bus.busy) stall = 0;
            case (rdy_mode)
                0: bus.res_ready = 1'b1;
                1: bus.res_ready = ($urandom_range(0, 1) == 1);
                default: if (bus.res_valid && bus.res_idx == 1 && stall < 5) begin
                    bus.res_ready = 1'b0;
                    stall++;
                end else bus.res_ready = 1'b1;
            endcase
        end
    end

    // Monitor: pops expectations whenever the DUT reads or hands over a result
    logic             hold = 1'b0;
    logic [ACC_W-1:0] hold_d;
    logic [OUT_W-1:0] hold_i;
    always @(negedge clk) begin
        if (reset) hold = 1'b0;
        else begin
            addr_t ea;
            res_t  er;
            if (bus.buf_rd_en) begin
                chk("rd_while_valid", bus.res_valid, 0);
                if (addr_q.size() == 0) chk("unexpected_rd", 1, 0);
                else begin
                    ea = addr_q.pop_front();
                    chk("act_addr", bus.act_addr, ea.a);
                    chk("wgt_addr", bus.wgt_addr, ea.w);
                end
            end
            if (bus.pe_en) begin
                if (cur_k == 0) chk("unexpected_pe_en", 1, 0);
                else chk("reg_reset_align", bus.pe_reg_reset, ((n_en - en_base) % cur_k) == 0);
                n_en++;
            end
            if (bus.pe_reg_reset) begin
                chk("reg_reset_without_en", bus.pe_en, 1);
                n_rr++;
            end
            if (hold) begin
                chk("stall_valid", bus.res_valid, 1);
                chk("stall_data", bus.res_data, hold_d);
                chk("stall_idx", bus.res_idx, hold_i);
            end
            if (bus.res_valid && bus.res_ready) begin
                if (res_q.size() == 0) chk("unexpected_result", 1, 0);
                else begin
                    er = res_q.pop_front();
                    chk("res_data", bus.res_data, er.d);
                    chk("res_idx", bus.res_idx, er.i);
                end
            end
            hold   = bus.res_valid && !bus.res_ready;
            hold_d = bus.res_data;
            hold_i = bus.res_idx;
            if (bus.done) begin
                n_done++;
                chk("busy_with_done", bus.busy, 0);
            end
            if (bus.busy) chk("mode_sel", bus.pe_mode_sel, exp_relu);
        end
    end

    task automatic push_expect(input int K, input int N, input int ab, input int wb, input bit relu);
        if (K == 0 || N == 0) return;
        for (int j = 0; j < N; j++) begin
            int s = 0;
            res_t r;
            for (int k = 0; k < K; k++) begin
                addr_t a;
                a.a = ADDR_W'((ab + k) % 1024);
                a.w = ADDR_W'((wb + j * K + k) % 1024);
                addr_q.push_back(a);
                s += int'(act_mem[a.a]) * int'(wgt_mem[a.w]);
            end
            if (relu && s < 0) s = 0;
            r.d = ACC_W'(s);
            r.i = OUT_W'(j);
            res_q.push_back(r);
        end
    endtask

    task automatic start_job(input int K, input int N, input int ab, input int wb, input bit relu);
        cur_k = K; en_base = n_en; rr_base = n_rr; done_base = n_done; exp_relu = relu;
        push_expect(K, N, ab, wb, relu);
        @(posedge clk); #1;
        bus.cfg_start = 1'b1;  bus.cfg_len = LEN_W'(K);  bus.cfg_num_out = OUT_W'(N);
        bus.cfg_act_base = ADDR_W'(ab);  bus.cfg_wgt_base = ADDR_W'(wb);  bus.cfg_relu = relu;
    endtask

    task automatic run_job(input int K, input int N, input int ab, input int wb,
                           input bit relu, input bit mid, input int rmode);
        int cyc = 0;
        int neff;
        bit got = 0;
        neff = (K == 0) ? 0 : N;
        rdy_mode = rmode;
        start_job(K, N, ab, wb, relu);
        while (!got && cyc < 4000) begin
            @(posedge clk); #1;
            cyc++;
            got = bus.done;
            bus.cfg_start = mid && (cyc == 1);
            if (bus.cfg_start) begin
                bus.cfg_len = 10'd7;  bus.cfg_num_out = 8'd3;  bus.cfg_act_base = 10'h155;
                bus.cfg_wgt_base = 10'h0AA;  bus.cfg_relu = ~relu;
            end
        end
        bus.cfg_start = 1'b0;
        chk("done_seen", got, 1);
        if (rmode == 0)
            chk("done_latency", cyc, (neff == 0) ? 2 : neff * (K + RD_LAT + PE_LAT + 1) + 2);
        repeat (3) @(posedge clk);
        #1;
        chk("done_pulses", n_done - done_base, 1);
        chk("reg_reset_pulses", n_rr - rr_base, neff);
        chk("pe_en_count", n_en - en_base, neff * K);
        chk("reads_left", addr_q.size(), 0);
        chk("results_left", res_q.size(), 0);
        chk("idle_busy", bus.busy, 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_rd_en"}, bus.buf_rd_en, 0);
        chk({tag, "_pe_en"}, bus.pe_en, 0);
        chk({tag, "_reg_reset"}, bus.pe_reg_reset, 0);
        chk({tag, "_mode_sel"}, bus.pe_mode_sel, 0);
        chk({tag, "_res_valid"}, bus.res_valid, 0);
        chk({tag, "_act_addr"}, bus.act_addr, 0);
        chk({tag, "_wgt_addr"}, bus.wgt_addr, 0);
        chk({tag, "_res_data"}, bus.res_data, 0);
        chk({tag, "_res_idx"}, bus.res_idx, 0);
    endtask

    initial begin
        int cyc = 0;
        #4_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        bus.cfg_start = 1'b0;  bus.cfg_len = '0;  bus.cfg_num_out = '0;
        bus.cfg_relu = 1'b0;  bus.cfg_act_base = '0;  bus.cfg_wgt_base = '0;
        for (int i = 0; i < 1024; i++) begin
            int t;
            t = int'($urandom_range(0, 15)) - 8;  act_mem[i] = t[7:0];
            t = int'($urandom_range(0, 15)) - 8;  wgt_mem[i] = t[7:0];
        end
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        reset = 1'b0;

        run_job(4, 2, 'h10, 'h100, 1'b0, 1'b0, 0);

        act_mem['h40] = 8'sd1;  act_mem['h41] = 8'sd2;  act_mem['h42] = 8'sd3;
        wgt_mem['h200] = -8'sd1; wgt_mem['h201] = 8'sd4; wgt_mem['h202] = -8'sd2;
        run_job(3, 1, 'h40, 'h200, 1'b1, 1'b0, 0);

        run_job(2, 3, 'h60, 'h220, 1'b0, 1'b0, 2);
        run_job(0, 5, 'h20, 'h30, 1'b0, 1'b1, 0);
        run_job(3, 0, 'h20, 'h30, 1'b1, 1'b0, 0);
        run_job(5, 2, 'h70, 'h2F0, 1'b1, 1'b1, 0);
        run_job(4, 1, 'h3FE, 'h3FD, 1'b0, 1'b0, 0);

        // Abort in the middle of ISSUE at k==2, then a clean job must follow
        rdy_mode = 0;
        start_job(6, 2, 'h80, 'h300, 1'b1);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            bus.cfg_start = 1'b0;
            cyc++;
        end while (!(bus.buf_rd_en && bus.act_addr == 10'h082) && cyc < 50);
        chk("reached_k2", cyc < 50, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check_zero("mid_reset");
        reset = 1'b0;
        addr_q.delete();
        res_q.delete();
        run_job(3, 2, 'h80, 'h300, 1'b0, 1'b0, 0);

        for (int t = 0; t < 8; t++)
            run_job($urandom_range(1, 6), $urandom_range(1, 3), $urandom_range(0, 1023),
                    $urandom_range(0, 1023), 1'($urandom_range(0, 1)), 1'b0, (t % 2 == 0) ? 1 : 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
